// File: rtl/axi_ddr_responder_model.sv
`default_nettype none
// ============================================================================
// Module   : axi_ddr_responder_model
// Purpose  : AXI responder for the DDR controller port (combined A channel,
//            W/B/R channels) backed by an on-chip byte-enabled RAM.
// Revision : 1.0 - initial release
// ============================================================================
module axi_ddr_responder_model #(
    parameter  int DATA_WIDTH = 128,
    parameter  int ID_WIDTH   = 8,
    parameter  int ADDR_WIDTH = 32,
    parameter  int MEM_AW     = 10,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    // combined address channel
    input  logic [ADDR_WIDTH-1:0] aaddr,
    input  logic [ID_WIDTH-1:0]   aid,
    input  logic [7:0]            alen,
    input  logic [2:0]            asize,
    input  logic [1:0]            aburst,
    input  logic [1:0]            alock,
    input  logic                  atype,
    input  logic                  avalid,
    output logic                  aready,
    // write data channel
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic [ID_WIDTH-1:0]   wid,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    // write response channel
    output logic [ID_WIDTH-1:0]   bid,
    output logic                  bvalid,
    input  logic                  bready,
    // read data channel
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    // sticky protocol error flags
    output logic                  err_wlast,
    output logic                  err_burst
);

    localparam int LSB   = $clog2(STRB_WIDTH);
    localparam int DEPTH = 1 << MEM_AW;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RPREP = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_aready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [1:0]            r_rresp;
    logic [ID_WIDTH-1:0]   r_id;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;
    logic [1:0]            r_burst;
    logic                  r_bad;
    logic [MEM_AW-1:0]     r_addr;
    logic                  r_err_wlast;
    logic                  r_err_burst;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_ram_q;

    logic                  w_a_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic                  w_last_beat;
    logic [MEM_AW-1:0]     w_addr_nxt;
    logic [MEM_AW-1:0]     w_rd_addr;
    logic                  w_we;
    logic                  w_re;
    logic                  w_unused;

    assign w_a_hs      = (r_state == S_IDLE)  && avalid && r_aready;
    assign w_w_hs      = (r_state == S_WRITE) && wvalid && r_wready;
    assign w_r_hs      = (r_state == S_READ)  && r_rvalid && rready;
    assign w_last_beat = (r_beat == r_len);

    // FIXED bursts hold the word address; INCR (and the unsupported codes) advance and wrap
    assign w_addr_nxt  = (r_burst == 2'b00) ? r_addr : r_addr + MEM_AW'(1);

    // Look ahead on a read handshake so a continuously ready master gets one beat per cycle
    assign w_rd_addr   = w_r_hs ? w_addr_nxt : r_addr;
    assign w_re        = (r_state == S_RPREP) || (r_state == S_READ);
    assign w_we        = w_w_hs && !r_bad && !axi_rst;

    assign w_unused    = ^{asize, alock, wid, aaddr};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_a_hs) begin
                    w_next = atype ? S_WRITE : S_RPREP;
                end
            end
            S_WRITE: begin
                if (w_w_hs && w_last_beat) begin
                    w_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (r_bvalid && bready) begin
                    w_next = S_IDLE;
                end
            end
            S_RPREP: begin
                w_next = S_READ;
            end
            S_READ: begin
                if (w_r_hs && r_rlast) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake outputs, burst tracking and error flags
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_aready    <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= 2'b00;
            r_id        <= '0;
            r_len       <= 8'd0;
            r_beat      <= 8'd0;
            r_burst     <= 2'b00;
            r_bad       <= 1'b0;
            r_addr      <= '0;
            r_err_wlast <= 1'b0;
            r_err_burst <= 1'b0;
        end else begin
            r_aready <= (w_next == S_IDLE);
            r_wready <= (w_next == S_WRITE);
            r_bvalid <= (w_next == S_WRESP);
            r_rvalid <= (w_next == S_READ);

            if (w_a_hs) begin
                r_id    <= aid;
                r_len   <= alen;
                r_burst <= aburst;
                r_addr  <= aaddr[MEM_AW+LSB-1:LSB];
                r_beat  <= 8'd0;
                r_bad   <= aburst[1];
                if (aburst[1]) begin
                    r_err_burst <= 1'b1;
                end
            end

            // Burst length is governed by alen alone; wlast is only audited
            if (w_w_hs) begin
                r_addr <= w_addr_nxt;
                r_beat <= r_beat + 8'd1;
                if (wlast != w_last_beat) begin
                    r_err_wlast <= 1'b1;
                end
            end

            if (r_state == S_RPREP) begin
                r_rlast <= (r_len == 8'd0);
                r_rresp <= r_bad ? 2'b10 : 2'b00;
            end

            if (w_r_hs) begin
                r_addr  <= w_addr_nxt;
                r_beat  <= r_beat + 8'd1;
                r_rlast <= ((r_beat + 8'd1) == r_len);
            end
        end
    end

    // ------------------------------------------------------------------
    // Byte-enabled RAM; contents survive reset
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_we && wstrb[i]) begin
                r_mem[r_addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_ram_q <= '0;
        end else if (w_re) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    assign aready    = r_aready;
    assign wready    = r_wready;
    assign bvalid    = r_bvalid;
    assign bid       = r_id;
    assign rvalid    = r_rvalid;
    assign rid       = r_id;
    assign rlast     = r_rlast;
    assign rresp     = r_rresp;
    assign rdata     = r_bad ? '0 : r_ram_q;
    assign err_wlast = r_err_wlast;
    assign err_burst = r_err_burst;

endmodule
`default_nettype wire

// File: tb/tb_axi_ddr_responder_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_ddr_responder_model
// Purpose  : Directed plus randomized bench with a word/byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_ddr_responder_model;

    localparam int DW    = 128;
    localparam int SW    = DW / 8;
    localparam int IW    = 8;
    localparam int AW    = 32;
    localparam int MAW   = 10;
    localparam int WORDS = 1 << MAW;

    logic          axi_clk = 1'b0;
    logic          axi_rst;
    logic [AW-1:0] aaddr;
    logic [IW-1:0] aid;
    logic [7:0]    alen;
    logic [2:0]    asize;
    logic [1:0]    aburst;
    logic [1:0]    alock;
    logic          atype;
    logic          avalid;
    logic          aready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [IW-1:0] wid;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [IW-1:0] bid;
    logic          bvalid;
    logic          bready;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;
    logic          err_wlast;
    logic          err_burst;

    axi_ddr_responder_model #(
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .ADDR_WIDTH (AW),
        .MEM_AW     (MAW)
    ) dut (
        .axi_clk   (axi_clk),
        .axi_rst   (axi_rst),
        .aaddr     (aaddr),
        .aid       (aid),
        .alen      (alen),
        .asize     (asize),
        .aburst    (aburst),
        .alock     (alock),
        .atype     (atype),
        .avalid    (avalid),
        .aready    (aready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wid       (wid),
        .wlast     (wlast),
        .wvalid    (wvalid),
        .wready    (wready),
        .bid       (bid),
        .bvalid    (bvalid),
        .bready    (bready),
        .rdata     (rdata),
        .rid       (rid),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .err_wlast (err_wlast),
        .err_burst (err_burst)
    );

    always #5 axi_clk = ~axi_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: data plus per-byte "has been written" flags
    logic [DW-1:0] m_mem   [WORDS];
    logic [SW-1:0] m_known [WORDS];
    logic          exp_err_wlast = 1'b0;
    logic          exp_err_burst = 1'b0;

    // Beat payloads for the next write burst
    logic [DW-1:0] t_data [256];
    logic [SW-1:0] t_strb [256];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [AW-1:0] addr, input logic [1:0] burst, input int beat);
        int base;
        base = int'((addr / SW) % WORDS);
        return (burst == 2'b00) ? base : (base + beat) % WORDS;
    endfunction

    function automatic logic [DW-1:0] byte_mask(input logic [SW-1:0] k);
        logic [DW-1:0] m;
        for (int i = 0; i < SW; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    task automatic send_addr(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input logic is_wr);
        int cnt;
        @(negedge axi_clk);
        aaddr = addr; aid = id; alen = len; aburst = burst; atype = is_wr; avalid = 1'b1;
        asize = 3'($urandom_range(0, 7)); alock = 2'($urandom_range(0, 3));
        cnt = 0;
        while (aready !== 1'b1 && cnt < 50) begin
            @(negedge axi_clk);
            cnt++;
        end
        chk("addr_accept_bound", cnt < 50, 1);
        @(negedge axi_clk);
        avalid = 1'b0;
        atype  = 1'b0;
        chk("aready_busy", aready, 0);
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                             input logic [1:0] burst, input int wlast_bad);
        int  cnt;
        int  a;
        int  n;
        send_addr(addr, id, len, burst, 1'b1);
        if (burst[1]) exp_err_burst = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(negedge axi_clk);
            end
            wvalid = 1'b1;
            wdata  = t_data[b];
            wstrb  = t_strb[b];
            wid    = IW'($urandom);
            wlast  = (b == int'(len)) ^ (b == wlast_bad);
            cnt = 0;
            while (wready !== 1'b1 && cnt < 50) begin
                @(negedge axi_clk);
                cnt++;
            end
            chk("wready_bound", cnt < 50, 1);
            @(negedge axi_clk);
            a = word_of(addr, burst, b);
            if (!burst[1]) begin
                for (int i = 0; i < SW; i++) begin
                    if (t_strb[b][i]) begin
                        m_mem[a][i*8 +: 8] = t_data[b][i*8 +: 8];
                        m_known[a][i]      = 1'b1;
                    end
                end
            end
            if (wlast != (b == int'(len))) exp_err_wlast = 1'b1;
            if (b < int'(len)) chk("bvalid_early", bvalid, 0);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("err_wlast", err_wlast, exp_err_wlast);
        chk("err_burst", err_burst, exp_err_burst);
        n = $urandom_range(0, 2);
        repeat (n) begin
            @(negedge axi_clk);
            chk("bvalid_hold", bvalid, 1);
            chk("bid_hold", bid, id);
            chk("aready_in_wresp", aready, 0);
        end
        bready = 1'b1;
        @(negedge axi_clk);
        bready = 1'b0;
        chk("bvalid_clear", bvalid, 0);
        chk("aready_idle", aready, 1);
    endtask

    // mode 0: rready always 1; mode 1: 1,0,1,0...; mode 2: random
    task automatic axi_read(input logic [AW-1:0] addr, input logic [IW-1:0] id, input logic [7:0] len,
                            input logic [1:0] burst, input int mode, input int abort_beat);
        int            a;
        int            cnt;
        bit            done;
        logic          tog;
        logic          rr;
        logic [DW-1:0] exp;
        logic [DW-1:0] msk;
        send_addr(addr, id, len, burst, 1'b0);
        if (burst[1]) exp_err_burst = 1'b1;
        chk("rvalid_prep", rvalid, 0);
        @(negedge axi_clk);
        tog = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            a   = word_of(addr, burst, b);
            exp = burst[1] ? '0 : m_mem[a];
            msk = burst[1] ? '1 : byte_mask(m_known[a]);
            if (b == abort_beat) begin
                rready  = 1'b0;
                axi_rst = 1'b1;
                @(negedge axi_clk);
                exp_err_wlast = 1'b0;
                exp_err_burst = 1'b0;
                chk("rst_mid_rvalid", rvalid, 0);
                chk("rst_mid_aready", aready, 0);
                chk("rst_mid_err_burst", err_burst, exp_err_burst);
                axi_rst = 1'b0;
                @(negedge axi_clk);
                chk("aready_after_rst", aready, 1);
                chk("rvalid_after_rst", rvalid, 0);
                return;
            end
            done = 1'b0;
            cnt  = 0;
            while (!done && cnt < 50) begin
                chk("rvalid", rvalid, 1);
                chk("rdata", rdata & msk, exp & msk);
                chk("rid", rid, id);
                chk("rresp", rresp, burst[1] ? 2'b10 : 2'b00);
                chk("rlast", rlast, b == int'(len));
                case (mode)
                    0:       rr = 1'b1;
                    1:       rr = tog;
                    default: rr = (cnt >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                endcase
                tog    = ~tog;
                rready = rr;
                @(negedge axi_clk);
                done = rr;
                cnt++;
            end
            chk("rbeat_bound", done, 1);
        end
        rready = 1'b0;
        chk("rvalid_after_last", rvalid, 0);
        chk("aready_after_read", aready, 1);
        chk("err_burst_r", err_burst, exp_err_burst);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] ra;
        logic [7:0]    rl;
        logic [1:0]    rb;
        for (int i = 0; i < WORDS; i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end
        axi_rst = 1'b1;
        aaddr = '0; aid = '0; alen = '0; asize = '0; aburst = '0; alock = '0; atype = 1'b0;
        avalid = 1'b0; wdata = '0; wstrb = '0; wid = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        repeat (3) @(negedge axi_clk);

        chk("rst_aready", aready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_err_wlast", err_wlast, 0);
        chk("rst_err_burst", err_burst, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rid", rid, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        axi_rst = 1'b0;
        @(negedge axi_clk);
        chk("aready_first", aready, 1);

        // wvalid while idle must not be taken
        wvalid = 1'b1;
        @(negedge axi_clk);
        chk("wready_idle", wready, 0);
        wvalid = 1'b0;

        // single beat write/read at 0x40
        t_data[0] = 128'h0123456789ABCDEF_0123456789ABCDEF;
        t_strb[0] = 16'hFFFF;
        axi_write(32'h40, 8'h5A, 8'd0, 2'b01, -1);
        axi_read(32'h40, 8'h5A, 8'd0, 2'b01, 0, -1);

        // INCR 4-beat write, read back with rready toggling
        for (int b = 0; b < 4; b++) begin
            t_data[b] = DW'(32'h100 + b);
            t_strb[b] = '1;
        end
        axi_write(32'h800, 8'h11, 8'd3, 2'b01, -1);
        axi_read(32'h800, 8'h12, 8'd3, 2'b01, 1, -1);

        // partial strobe
        t_data[0] = '1;
        t_strb[0] = '1;
        axi_write(32'h200, 8'h21, 8'd0, 2'b01, -1);
        t_data[0] = '0;
        t_strb[0] = 16'h000F;
        axi_write(32'h200, 8'h22, 8'd0, 2'b01, -1);
        axi_read(32'h200, 8'h23, 8'd0, 2'b01, 0, -1);

        // FIXED burst: only the last beat survives
        t_data[0] = {4{32'hAAAA_AAAA}};
        t_data[1] = {4{32'hBBBB_BBBB}};
        t_data[2] = {4{32'hCCCC_CCCC}};
        for (int b = 0; b < 3; b++) t_strb[b] = '1;
        axi_write(32'h300, 8'h31, 8'd2, 2'b00, -1);
        axi_read(32'h300, 8'h32, 8'd0, 2'b01, 0, -1);

        // INCR read across the top of the RAM wraps to word 0
        t_data[0] = {4{32'h1111_2222}};
        t_strb[0] = '1;
        axi_write(32'((WORDS - 1) * SW), 8'h41, 8'd0, 2'b01, -1);
        t_data[0] = {4{32'h3333_4444}};
        axi_write(32'h0, 8'h42, 8'd0, 2'b01, -1);
        axi_read(32'((WORDS - 1) * SW), 8'h43, 8'd1, 2'b01, 0, -1);

        // randomized write/read-back traffic
        for (int t = 0; t < 16; t++) begin
            ra = {$urandom_range(0, 255) == 0 ? 18'h3FFFF : 18'($urandom), 10'($urandom), 4'($urandom)};
            rl = 8'($urandom_range(0, 7));
            rb = 2'($urandom_range(0, 1));
            for (int b = 0; b <= int'(rl); b++) begin
                t_data[b] = {$urandom, $urandom, $urandom, $urandom};
                t_strb[b] = ($urandom_range(0, 2) == 0) ? SW'($urandom) : '1;
            end
            axi_write(ra, 8'($urandom), rl, rb, -1);
            axi_read(ra, 8'($urandom), rl, rb, 2, -1);
        end

        // unsupported burst type, then a normal write
        axi_read(32'h40, 8'h66, 8'd1, 2'b10, 0, -1);
        chk("err_burst_set", err_burst, 1);
        t_data[0] = {4{32'h5555_6666}};
        t_strb[0] = '1;
        axi_write(32'h500, 8'h67, 8'd0, 2'b01, -1);
        axi_read(32'h500, 8'h68, 8'd0, 2'b01, 0, -1);

        // early wlast on beat 1 of a 4-beat burst
        for (int b = 0; b < 4; b++) begin
            t_data[b] = {$urandom, $urandom, $urandom, $urandom};
            t_strb[b] = '1;
        end
        axi_write(32'h600, 8'h71, 8'd3, 2'b01, 1);
        chk("err_wlast_set", err_wlast, 1);
        axi_read(32'h600, 8'h72, 8'd3, 2'b01, 0, -1);

        // reset in the middle of a read burst, then re-read
        axi_read(32'h800, 8'h81, 8'd3, 2'b01, 0, 2);
        axi_read(32'h800, 8'h82, 8'd3, 2'b01, 2, -1);
        chk("err_wlast_cleared", err_wlast, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_ddr_responder_model.md
Name: axi_ddr_responder_model

Overview:
- AXI responder (slave) for the DDR controller port protocol that the LPDDR3 memory checker drives: one combined address channel (atype selects write or read), plus W, B and R channels.
- Backs all accesses with an on-chip byte-enabled RAM.
- Stands in for the hard DDR controller, either as a simulation model or as a fabric loopback target, so the checker's pass/done logic can be exercised without LPDDR3 silicon.
- Serves one transaction at a time.

Parameters:
- DATA_WIDTH, 128, data bus width in bits (128 or 256); STRB_WIDTH = DATA_WIDTH/8.
- ID_WIDTH, 8, width of aid/wid/bid/rid.
- ADDR_WIDTH, 32, width of aaddr.
- MEM_AW, 10, log2 of RAM depth in DATA_WIDTH words.

Ports:
- axi_clk  in  1  single clock for all logic.
- axi_rst  in  1  synchronous, active-high reset.
- aaddr  in  ADDR_WIDTH  byte address.
- aid  in  ID_WIDTH  transaction ID.
- alen  in  8  beats minus one.
- asize  in  3  beat size; ignored, full width assumed.
- aburst  in  2  burst type: 00 FIXED, 01 INCR, 10/11 unsupported.
- alock  in  2  ignored.
- atype  in  1  1 = write, 0 = read.
- avalid  in  1  address valid.
- aready  out  1  address ready.
- wdata  in  DATA_WIDTH  write data.
- wstrb  in  STRB_WIDTH  byte enables.
- wid  in  ID_WIDTH  ignored.
- wlast  in  1  last write beat.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bid  out  ID_WIDTH  response ID.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- rdata  out  DATA_WIDTH  read data.
- rid  out  ID_WIDTH  read ID.
- rresp  out  2  00 OKAY, 10 SLVERR.
- rlast  out  1  last read beat.
- rvalid  out  1  read valid.
- rready  in  1  read ready.
- err_wlast  out  1  sticky: wlast did not match the beat count.
- err_burst  out  1  sticky: unsupported aburst received.

Behaviour:
- Reset (synchronous, axi_rst=1):
  - aready, wready, bvalid, rvalid, rlast, err_wlast and err_burst go to 0.
  - bid, rid, rresp and rdata go to 0.
  - FSM goes to IDLE.
  - RAM contents are preserved.
  - Reset mid-burst abandons the transaction with no response; the first cycle after reset has aready=1.
- FSM states: IDLE, WRITE, WRESP, RPREP, READ.
- IDLE:
  - aready=1 (registered; deasserted in every other state).
  - On avalid&aready, latch aid, alen, aburst and word address aaddr[MEM_AW+LSB-1:LSB], where LSB = log2(STRB_WIDTH); clear beat counter.
  - atype=1 goes to WRITE; atype=0 goes to RPREP.
  - aburst in {10,11} sets err_burst and an internal bad flag.
- WRITE:
  - wready=1.
  - Each wvalid&wready beat writes RAM[addr] for bytes with wstrb[i]=1, unless bad.
  - INCR: addr+1, modulo 2^MEM_AW (wraps silently). FIXED: addr held.
  - Beat number alen is the final beat and goes to WRESP.
  - If wlast != (beat==alen) on any beat, set err_wlast. Termination is by count only.
- WRESP:
  - bvalid=1, bid = latched aid, both stable until bready.
  - On bvalid&bready, go to IDLE.
- RPREP:
  - One cycle; RAM read issued at addr.
  - Go to READ with rvalid=1.
  - First rvalid appears 2 cycles after the address handshake.
- READ:
  - rvalid=1, rid = latched aid, rlast = (beat==alen).
  - rresp = 10 if bad, else 00. When bad, rdata is forced to 0.
  - rdata, rid, rresp and rlast stay stable while rvalid&!rready.
  - RAM read address = handshake ? next addr : addr, so rready held at 1 gives 1 beat/cycle.
  - Handshake on the rlast beat goes to IDLE, with rvalid=0 the next cycle.
- Simultaneous events:
  - avalid asserted outside IDLE is not accepted and must stay pending.
  - wvalid in IDLE is ignored (wready=0).
- alen=0 is a single beat with rlast=1 on the first beat.
- A zero wstrb beat counts as a beat but writes nothing.

Test Plan:
- Write, INCR, aaddr=0x40 (DATA_WIDTH=128), alen=0, wdata=0x0123..CDEF, wstrb=0xFFFF, aid=0x5A -> one write then bvalid with bid=0x5A. Read of the same address -> rdata=0x0123..CDEF, rlast=1, rresp=00 on the first rvalid, 2 cycles after the handshake.
- INCR alen=3 write of 0x100 to 0x103, then read with rready toggling 1,0,1,0 -> 4 beats 0x100 to 0x103 in order, data held stable during stalls, rlast only on beat 4.
- Partial strobe: write 0xFF..FF, then 0x00..00 with wstrb=0x000F -> readback has its low 4 bytes 0x00 and the rest 0xFF.
- FIXED burst alen=2 writing A, B, C -> a single-beat read returns C. An INCR read at the top word (addr = 2^MEM_AW-1), alen=1 -> second beat comes from word 0.
- aburst=10 read alen=1 -> err_burst=1, 2 beats with rresp=10 and rdata=0. Follow-up valid write: err_burst stays 1, response is normal.
- wlast asserted on beat 1 of alen=3 -> err_wlast=1, burst still completes after 4 beats. Then axi_rst mid read burst -> rvalid=0 next cycle, aready=1 after release, RAM data intact on re-read.
